// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// Serial receive stage of the UART peripheral. Synchronizes the asynchronous
// rx line and validates the start bit at mid-bit. It then samples 8 data bits
// LSB-first and the stop bit, each at the middle of the bit. The received byte
// is delivered with a done pulse, a sticky ready flag and sticky error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frame, PARITY state between DATA and STOP, parity_err_o live
//   undefined -> 8N1 frame, PARITY unreachable, parity_err_o tied to 0
//
// Parameters:
//   BAUD_DIV   clk cycles per bit (even, >= 8)
//   CNT_W      baud counter width, must hold BAUD_DIV-1
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   rx_i          serial line, asynchronous, idle high
//   clr_flag_i    one-cycle CPU read strobe, clears the sticky flags
//   rx_data_o     last correctly framed byte
//   rx_done_o     one-cycle pulse when rx_data_o updates
//   rx_flag_o     sticky byte-available flag
//   frame_err_o   sticky framing error (stop bit low)
//   parity_err_o  sticky parity error (0 without the parity feature)
//   rx_busy_o     high whenever the FSM is not in IDLE
//   rx_state_o    current state encoding, for debug
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
   parameter int unsigned BAUD_DIV = 5208,
   parameter int unsigned CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic       clr_flag_i,
   output logic [7:0] rx_data_o,
   output logic       rx_done_o,
   output logic       rx_flag_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       rx_busy_o,
   output logic [2:0] rx_state_o
);

   localparam logic [CNT_W-1:0] LP_HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] LP_FULL_M1 = CNT_W'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_START  = 3'b001,
      S_DATA   = 3'b010,
      S_PARITY = 3'b011,
      S_STOP   = 3'b100,
      S_DONE   = 3'b101,
      S_BREAK  = 3'b110
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic             r_rx_meta;
   logic             r_rx_s;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_done;
   logic             r_flag;
   logic             r_ferr;
   logic             r_busy;

   logic             w_half_hit;
   logic             w_full_hit;
   logic             w_counting;
   logic             w_bit_tick;
   logic             w_load;
   logic             w_set_ferr;
   logic             w_set_flag;
   logic             w_cnt_clr;
`ifdef UART_RX_PARITY_EN
   logic             w_set_perr;
   logic             r_perr;
`endif

   assign w_half_hit = (r_cnt == LP_HALF_M1);
   assign w_full_hit = (r_cnt == LP_FULL_M1);

   // Two-flop synchronizer; resets to the idle line level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx_i;
         r_rx_s    <= r_rx_meta;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state and control strobes
   always_comb begin
      w_state_next = r_state;
      w_counting   = 1'b0;
      w_bit_tick   = 1'b0;
      w_load       = 1'b0;
      w_set_ferr   = 1'b0;
      w_set_flag   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_set_perr   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) w_state_next = S_START;
         end
         S_START: begin
            w_counting = 1'b1;
            // A line already back high at mid start bit was a glitch
            if (w_half_hit) w_state_next = r_rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            w_counting = 1'b1;
            if (w_full_hit) begin
               w_bit_tick = 1'b1;
               if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_STOP;
`endif
               end
            end
         end
         S_PARITY: begin
            w_counting = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (w_full_hit) begin
               // Even parity: the parity bit must equal the XOR of the data
               w_set_perr   = (r_rx_s != ^r_shift);
               w_state_next = S_STOP;
            end
`else
            w_state_next = S_IDLE;
`endif
         end
         S_STOP: begin
            w_counting = 1'b1;
            if (w_full_hit) begin
               if (r_rx_s) begin
                  w_load       = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_set_ferr   = 1'b1;
                  w_state_next = S_BREAK;
               end
            end
         end
         S_DONE: begin
            // Flag sets on the way out of DONE, so a CPU clear issued while
            // rx_done_o is high cannot swallow the new byte's flag
            w_set_flag   = 1'b1;
            w_state_next = S_IDLE;
         end
         S_BREAK: begin
            // Wait for the line to return high before rearming
            if (r_rx_s) w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Baud counter clears on every state entry and after each data bit
   assign w_cnt_clr = (w_state_next != r_state) || w_bit_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_cnt <= '0;
      else if (w_cnt_clr)  r_cnt <= '0;
      else if (w_counting) r_cnt <= r_cnt + CNT_W'(1);
   end

   // Bit counter and shift register; first received bit lands in bit 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         if (r_state != S_DATA) r_bit_cnt <= 3'd0;
         else if (w_bit_tick)   r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_bit_tick)        r_shift   <= {r_rx_s, r_shift[7:1]};
      end
   end

   // Registered outputs; a set in the same cycle as a clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= 8'd0;
         r_done <= 1'b0;
         r_flag <= 1'b0;
         r_ferr <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_done <= w_load;
         r_busy <= (w_state_next != S_IDLE);
         if (w_load) r_data <= r_shift;
         if (w_set_flag)      r_flag <= 1'b1;
         else if (clr_flag_i) r_flag <= 1'b0;
         if (w_set_ferr)      r_ferr <= 1'b1;
         else if (clr_flag_i) r_ferr <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Sticky parity error
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_perr <= 1'b0;
      else if (w_set_perr) r_perr <= 1'b1;
      else if (clr_flag_i) r_perr <= 1'b0;
   end
   assign parity_err_o = r_perr;
`else
   assign parity_err_o = 1'b0;
`endif

   assign rx_data_o   = r_data;
   assign rx_done_o   = r_done;
   assign rx_flag_o   = r_flag;
   assign frame_err_o = r_ferr;
   assign rx_busy_o   = r_busy;
   assign rx_state_o  = r_state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Self-checking bench for uart_rx_fsm with BAUD_DIV=16. Expected bytes are
// queued as frames are driven and compared when rx_done_o pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fsm;

   localparam int unsigned BD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic       clr_flag_i;
   logic [7:0] rx_data_o;
   logic       rx_done_o;
   logic       rx_flag_o;
   logic       frame_err_o;
   logic       parity_err_o;
   logic       rx_busy_o;
   logic [2:0] rx_state_o;

   int         n_chk    = 0;
   int         n_fail   = 0;
   int         done_cnt = 0;
   int         n_exp    = 0;
   longint     t_last   = 0;
   longint     t_prev   = 0;
   logic [7:0] exp_q[$];

   uart_rx_fsm #(.BAUD_DIV(BD), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx_i),
      .clr_flag_i   (clr_flag_i),
      .rx_data_o    (rx_data_o),
      .rx_done_o    (rx_done_o),
      .rx_flag_o    (rx_flag_o),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .rx_busy_o    (rx_busy_o),
      .rx_state_o   (rx_state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest queued byte
   always @(negedge clk) begin
      if (rx_done_o) begin
         done_cnt++;
         t_prev = t_last;
         t_last = $time;
         chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
      end
   end

   task automatic push(input logic [7:0] d);
      exp_q.push_back(d);
      n_exp++;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      rx_i = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         repeat (BD) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx_i = par;
      repeat (BD) @(negedge clk);
`endif
      rx_i = stop;
      repeat (BD) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_flag_i = 1'b1;
      @(negedge clk);
      clr_flag_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int i;
      for (i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (rx_done_o) break;
      end
      if (i == max_cyc) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int base;
      longint gap;
      rst        = 1'b1;
      rx_i       = 1'b1;
      clr_flag_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data",  32'(rx_data_o),   32'h00);
      chk("rst_done",  32'(rx_done_o),   32'd0);
      chk("rst_flag",  32'(rx_flag_o),   32'd0);
      chk("rst_ferr",  32'(frame_err_o), 32'd0);
      chk("rst_busy",  32'(rx_busy_o),   32'd0);
      chk("rst_state", 32'(rx_state_o),  32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Good byte, then CPU clear
      push(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("a5_data", 32'(rx_data_o),   32'hA5);
      chk("a5_flag", 32'(rx_flag_o),   32'd1);
      chk("a5_ferr", 32'(frame_err_o), 32'd0);
      chk("a5_cnt",  32'(done_cnt),    32'd1);
      pulse_clr();
      chk("a5_clr_flag", 32'(rx_flag_o), 32'd0);

      // Glitch rejection
      rx_i = 1'b0;
      repeat (4) @(negedge clk);
      rx_i = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_state", 32'(rx_state_o),  32'd0);
      chk("glitch_busy",  32'(rx_busy_o),   32'd0);
      chk("glitch_flag",  32'(rx_flag_o),   32'd0);
      chk("glitch_ferr",  32'(frame_err_o), 32'd0);
      chk("glitch_cnt",   32'(done_cnt),    32'd1);
      push(8'h3C);
      send_frame(8'h3C, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("3c_data", 32'(rx_data_o), 32'h3C);
      chk("3c_flag", 32'(rx_flag_o), 32'd1);
      pulse_clr();

      // Framing error with the line held low afterwards
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      chk("fe_ferr",  32'(frame_err_o), 32'd1);
      chk("fe_state", 32'(rx_state_o),  32'd6);
      chk("fe_busy",  32'(rx_busy_o),   32'd1);
      chk("fe_data",  32'(rx_data_o),   32'h3C);
      chk("fe_flag",  32'(rx_flag_o),   32'd0);
      chk("fe_cnt",   32'(done_cnt),    32'd2);
      rx_i = 1'b1;
      repeat (4) @(negedge clk);
      chk("fe_idle", 32'(rx_state_o), 32'd0);
      pulse_clr();
      chk("fe_clr", 32'(frame_err_o), 32'd0);
      repeat (4) @(negedge clk);

      // Back-to-back frames; clear coincident with the second done
      push(8'h00);
      push(8'hFF);
      base = done_cnt;
      fork
         begin
            send_frame(8'h00, 1'b0, 1'b1);
            send_frame(8'hFF, 1'b0, 1'b1);
         end
         begin
            wait_done("b2b_first_timeout", 200);
            wait_done("b2b_second_timeout", 200);
            clr_flag_i = 1'b1;
            @(negedge clk);
            clr_flag_i = 1'b0;
            chk("b2b_flag_kept", 32'(rx_flag_o), 32'd1);
         end
      join
      repeat (2) @(negedge clk);
      chk("b2b_cnt",  32'(done_cnt - base), 32'd2);
      gap = (t_last - t_prev) / 10;
      chk("b2b_gap_160", 32'(gap >= 159 && gap <= 161), 32'd1);
      chk("b2b_data", 32'(rx_data_o), 32'hFF);

      // Reset during the 4th data bit of a frame
      rx_i = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_i = 1'b1;
         repeat (BD) @(negedge clk);
      end
      rx_i = 1'b0;
      repeat (BD / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_data",  32'(rx_data_o),  32'h00);
      chk("mid_rst_flag",  32'(rx_flag_o),  32'd0);
      chk("mid_rst_busy",  32'(rx_busy_o),  32'd0);
      chk("mid_rst_state", 32'(rx_state_o), 32'd0);
      chk("mid_rst_done",  32'(rx_done_o),  32'd0);
      @(negedge clk);
      rx_i = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (BD) @(negedge clk);
      push(8'h81);
      send_frame(8'h81, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("81_data", 32'(rx_data_o), 32'h81);
      chk("81_flag", 32'(rx_flag_o), 32'd1);
      pulse_clr();

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so the parity bit must be 1
      push(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      chk("par_ok_perr", 32'(parity_err_o), 32'd0);
      chk("par_ok_data", 32'(rx_data_o),    32'h07);
      pulse_clr();
      push(8'h07);
      send_frame(8'h07, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("par_bad_perr", 32'(parity_err_o), 32'd1);
      chk("par_bad_data", 32'(rx_data_o),    32'h07);
      chk("par_bad_flag", 32'(rx_flag_o),    32'd1);
      pulse_clr();
      chk("par_clr", 32'(parity_err_o), 32'd0);
`else
      chk("perr_tied", 32'(parity_err_o), 32'd0);
`endif

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("done_total",  32'(done_cnt),     32'(n_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Serial receive stage of the UART peripheral, the receive-side counterpart to the transmitter FSM in the same peripheral. It samples the asynchronous rx line, detects and validates the start bit, and mid-bit samples 8 data bits LSB-first plus a stop bit (8N1). It delivers the received byte with a done pulse, a sticky ready flag and a framing error to the peripheral's memory-mapped register interface. Baud timing is internal; no shared baud generator.

Parameters:
BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600); minimum 8, even values only
CNT_W, 16, width of baud counter; must hold BAUD_DIV-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
rx_i  input  1  serial line, asynchronous to clk, idle high
clr_flag_i  input  1  one-cycle pulse from CPU read; clears rx_flag_o, frame_err_o, parity_err_o
rx_data_o  output  8  last correctly framed byte; held until the next good frame
rx_done_o  output  1  one-cycle pulse when rx_data_o updates
rx_flag_o  output  1  sticky "byte available"
frame_err_o  output  1  sticky, stop bit sampled low
parity_err_o  output  1  sticky parity mismatch; constant 0 without the optional feature
rx_busy_o  output  1  high in every state except IDLE
rx_state_o  output  3  current state encoding, for debug

Behaviour:
- Reset: all outputs 0. State IDLE. Both synchronizer flops reset to 1.
- rx_i passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- Baud counter: cleared on every state entry. Increments each cycle while in START, DATA, PARITY or STOP.
- Encodings: IDLE=000, START=001, DATA=010, PARITY=011, STOP=100, DONE=101, BREAK=110.
- IDLE: rx_s==0 -> START.
- START: at count == BAUD_DIV/2-1, sample rx_s. If 0 -> DATA; if 1 -> IDLE (glitch rejected; no flag, no error).
- DATA: at count == BAUD_DIV-1, shift rx_s into the shift register MSB (shift right, so the first received bit ends in bit 0). Increment the 3-bit bit counter and clear the baud counter. After the 8th bit -> STOP, or PARITY when the optional feature is enabled.
- STOP: at count == BAUD_DIV-1, sample rx_s. If 1 -> DONE. If 0 -> set frame_err_o, do not update rx_data_o, go to BREAK.
- BREAK: remain until rx_s==1, then -> IDLE. This prevents a held-low line from retriggering reception.
- DONE: lasts one cycle. rx_data_o <= shift register, rx_done_o=1, rx_flag_o set. Then -> IDLE.
- Latency: rx_done_o asserts 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after the rx_i falling edge, ±1 cycle. Add BAUD_DIV when parity is enabled.
- Back-to-back frames: a start bit that begins immediately after the stop bit is received. IDLE accepts a start bit on its first cycle.
- Sticky flags: a set in the same cycle as clr_flag_i wins; the flag stays 1.
- Overrun: a new good frame overwrites rx_data_o and keeps rx_flag_o at 1. No overrun error is reported.
- Reset mid-frame: aborts immediately to IDLE with outputs 0. The partial byte is discarded.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state follows DATA. At count == BAUD_DIV-1, sample the parity bit and compare it with the XOR of the 8 data bits (even parity). On mismatch, set parity_err_o; the byte is still delivered via DONE unless a framing error also occurs. Frame is 8E1.
- Undefined: PARITY state is unreachable. DATA goes directly to STOP. parity_err_o is tied to 0. Frame is 8N1.

Test Plan:
- Good byte: BAUD_DIV=16, send 0xA5 in 8N1 -> one rx_done_o pulse, rx_data_o=0xA5, rx_flag_o=1, frame_err_o=0; then pulse clr_flag_i -> rx_flag_o=0.
- Glitch rejection: rx_i low for 4 cycles, then high -> return to IDLE, no rx_done_o, no flags; a following 0x3C frame is received correctly.
- Framing error: send 0x55 with stop bit low, line held low for 40 cycles -> frame_err_o=1, rx_data_o unchanged, FSM stays in BREAK until rx high, no rx_done_o.
- Back-to-back: 0x00 then 0xFF with zero idle gap -> two rx_done_o pulses 160±1 cycles apart, data 0x00 then 0xFF; clr_flag_i coincident with the second done leaves rx_flag_o=1.
- Reset mid-frame: assert rst during the 4th data bit -> all outputs 0 immediately; next 0x81 frame received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err_o=0; same byte with parity bit 0 -> parity_err_o=1, rx_data_o=0x07.
